cp0_exc_ctrl: RTL and testbench

Parametrised second-generation coprocessor 0 for the single-cycle MIPS CPU. It holds the architected Count, Compare, Status, Cause and EPC registers, and serves MFC0/MTC0. It arbitrates synchronous exceptions (SYSCALL, BREAK, TEQ) against masked external and timer interrupts, and handles ERET. It sits beside the register file and drives the PC mux with an exception-entry pulse, the handler vector and the return address.

---
 rtl/cp0_exc_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor 0 for the single-cycle MIPS core.
// Holds Count, Compare, Status, Cause and EPC, and serves MFC0/MTC0.
// Arbitrates SYSCALL/BREAK/TEQ against masked interrupts and handles ERET.
// Exception entry and return are signalled to the PC mux as one-cycle pulses.
// The Cause layout puts TI at bit 30, so DATA_W must be at least 31.
module cp0_exc_ctrl #(
    parameter int                DATA_W     = 32,
    parameter int                NUM_IRQ    = 6,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h0000_4180,
    parameter bit                TIMER_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         op,
    input  logic [4:0]         sel,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               teq_cond,
    input  logic [DATA_W-1:0]  pc_in,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [DATA_W-1:0]  rdata,
    output logic               exc_req,
    output logic [DATA_W-1:0]  exc_vector,
    output logic [DATA_W-1:0]  epc_out,
    output logic               eret_req
);

    localparam logic [2:0] OP_MFC0    = 3'b001;
    localparam logic [2:0] OP_MTC0    = 3'b010;
    localparam logic [2:0] OP_SYSCALL = 3'b011;
    localparam logic [2:0] OP_BREAK   = 3'b100;
    localparam logic [2:0] OP_TEQ     = 3'b101;
    localparam logic [2:0] OP_ERET    = 3'b110;

    localparam logic [4:0] SEL_COUNT   = 5'd9;
    localparam logic [4:0] SEL_COMPARE = 5'd11;
    localparam logic [4:0] SEL_STATUS  = 5'd12;
    localparam logic [4:0] SEL_CAUSE   = 5'd13;
    localparam logic [4:0] SEL_EPC     = 5'd14;

    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic              ie_q, ie_d;
    logic              exl_q, exl_d;
    logic [7:0]        im_q, im_d;
    logic [4:0]        exccode_q, exccode_d;
    logic [7:0]        ip_q, ip_d;
    logic              ti_q, ti_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              exc_req_q, exc_req_d;
    logic              eret_req_q, eret_req_d;

    logic [5:0]        irq_ip;
    logic [DATA_W-1:0] status_val;
    logic [DATA_W-1:0] cause_val;
    logic [DATA_W-1:0] rd_val;
    logic              int_pend;
    logic              take_int;
    logic              sync_exc;
    logic [4:0]        sync_code;
    logic              ti_clr;

    // Map the external lines onto IP[7:2]; unused positions read as 0.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_irq_ip
            if (gi < NUM_IRQ) begin : g_line
                assign irq_ip[gi] = irq[gi];
            end else begin : g_none
                assign irq_ip[gi] = 1'b0;
            end
        end
    endgenerate

    // Assemble the architected views of Status and Cause and the MFC0 read mux.
    always_comb begin
        status_val       = '0;
        status_val[0]    = ie_q;
        status_val[1]    = exl_q;
        status_val[15:8] = im_q;
        cause_val        = '0;
        cause_val[6:2]   = exccode_q;
        cause_val[15:8]  = ip_q;
        cause_val[30]    = ti_q;
        case (sel)
            SEL_COUNT:   rd_val = count_q;
            SEL_COMPARE: rd_val = compare_q;
            SEL_STATUS:  rd_val = status_val;
            SEL_CAUSE:   rd_val = cause_val;
            SEL_EPC:     rd_val = epc_q;
            default:     rd_val = '0;
        endcase
    end

    // Next-state logic: op decode, exception arbitration, timer and IP update.
    always_comb begin
        count_d    = count_q;
        compare_d  = compare_q;
        ie_d       = ie_q;
        exl_d      = exl_q;
        im_d       = im_q;
        exccode_d  = exccode_q;
        ip_d       = {irq_ip, ip_q[1:0]};
        ti_d       = ti_q;
        epc_d      = epc_q;
        rdata_d    = rdata_q;
        exc_req_d  = 1'b0;
        eret_req_d = 1'b0;
        sync_exc   = 1'b0;
        sync_code  = 5'd0;
        ti_clr     = 1'b0;

        // Arbitration looks only at pre-edge state, so an MTC0 to Status
        // cannot influence the same cycle's decision.
        int_pend = ie_q & ~exl_q & (|(ip_q & im_q));

        if (TIMER_EN) begin
            count_d = count_q + 1'b1;
        end

        case (op)
            OP_MFC0: rdata_d = rd_val;
            OP_MTC0: begin
                case (sel)
                    SEL_COUNT: begin
                        if (TIMER_EN) count_d = wdata;
                    end
                    SEL_COMPARE: begin
                        if (TIMER_EN) begin
                            compare_d = wdata;
                            ti_clr    = 1'b1;
                        end
                    end
                    SEL_STATUS: begin
                        ie_d  = wdata[0];
                        exl_d = wdata[1];
                        im_d  = wdata[15:8];
                    end
                    SEL_CAUSE: ip_d[1:0] = wdata[9:8];
                    SEL_EPC:   epc_d     = wdata;
                    default: ;
                endcase
            end
            OP_SYSCALL: begin
                sync_exc  = 1'b1;
                sync_code = 5'd8;
            end
            OP_BREAK: begin
                sync_exc  = 1'b1;
                sync_code = 5'd9;
            end
            OP_TEQ: begin
                if (teq_cond) begin
                    sync_exc  = 1'b1;
                    sync_code = 5'd13;
                end
            end
            OP_ERET: begin
                eret_req_d = 1'b1;
                if (exl_q) begin
                    exl_d     = 1'b0;
                    exccode_d = 5'd0;
                end
            end
            default: ;
        endcase

        // ERET and MTC0 cycles never also take an interrupt; it stays pending.
        take_int = int_pend && (op != OP_ERET) && (op != OP_MTC0);

        // Synchronous ops win over interrupts; with EXL set everything is dropped.
        if (!exl_q && (sync_exc || take_int)) begin
            epc_d     = pc_in;
            exl_d     = 1'b1;
            exccode_d = sync_exc ? sync_code : 5'd0;
            exc_req_d = 1'b1;
        end

        // Compare against next-cycle values so TI rises with Count reaching Compare.
        if (ti_clr) begin
            ti_d = 1'b0;
        end else if (TIMER_EN && (count_d == compare_d)) begin
            ti_d = 1'b1;
        end
        ip_d[7] = ip_d[7] | ti_d;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            compare_q  <= '0;
            ie_q       <= 1'b1;
            exl_q      <= 1'b0;
            im_q       <= '0;
            exccode_q  <= '0;
            ip_q       <= '0;
            ti_q       <= 1'b0;
            epc_q      <= '0;
            rdata_q    <= '0;
            exc_req_q  <= 1'b0;
            eret_req_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            im_q       <= im_d;
            exccode_q  <= exccode_d;
            ip_q       <= ip_d;
            ti_q       <= ti_d;
            epc_q      <= epc_d;
            rdata_q    <= rdata_d;
            exc_req_q  <= exc_req_d;
            eret_req_q <= eret_req_d;
        end
    end

    assign rdata      = rdata_q;
    assign exc_req    = exc_req_q;
    assign eret_req   = eret_req_q;
    assign epc_out    = epc_q;
    assign exc_vector = EXC_VECTOR;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl (default parameters).
// Each driven op pushes its expected outputs into a scoreboard queue; the
// entry is popped and compared one cycle later when the DUT output is valid.
module tb_cp0_exc_ctrl;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MFC0 = 3'd1;
    localparam logic [2:0] OP_MTC0 = 3'd2;
    localparam logic [2:0] OP_SYS  = 3'd3;
    localparam logic [2:0] OP_BRK  = 3'd4;
    localparam logic [2:0] OP_TEQ  = 3'd5;
    localparam logic [2:0] OP_ERET = 3'd6;

    logic        clk;
    logic        rst;
    logic [2:0]  op;
    logic [4:0]  sel;
    logic [31:0] wdata;
    logic        teq_cond;
    logic [31:0] pc_in;
    logic [5:0]  irq;
    logic [31:0] rdata;
    logic        exc_req;
    logic [31:0] exc_vector;
    logic [31:0] epc_out;
    logic        eret_req;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [4:0]  sel;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [5:0]  irq;
        logic        teq;
        logic        exc;
        logic        eret;
        logic        chk_rd;
        logic [31:0] rd;
        logic        chk_epc;
        logic [31:0] epc;
    } step_t;

    step_t sb[$];

    cp0_exc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .sel        (sel),
        .wdata      (wdata),
        .teq_cond   (teq_cond),
        .pc_in      (pc_in),
        .irq        (irq),
        .rdata      (rdata),
        .exc_req    (exc_req),
        .exc_vector (exc_vector),
        .epc_out    (epc_out),
        .eret_req   (eret_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t mk(string n, logic [2:0] o, logic [4:0] sl, logic [31:0] wd,
                                 logic [31:0] pc, logic [5:0] iq, logic tq, logic x, logic r,
                                 logic crd, logic [31:0] rd, logic cep, logic [31:0] ep);
        step_t s;
        s.name = n; s.op = o; s.sel = sl; s.wdata = wd; s.pc = pc; s.irq = iq; s.teq = tq;
        s.exc = x; s.eret = r; s.chk_rd = crd; s.rd = rd; s.chk_epc = cep; s.epc = ep;
        return s;
    endfunction

    // Drive one op and record what the DUT must show after the next edge.
    task automatic apply(input step_t s);
        op       = s.op;
        sel      = s.sel;
        wdata    = s.wdata;
        pc_in    = s.pc;
        irq      = s.irq;
        teq_cond = s.teq;
        sb.push_back(s);
    endtask

    task automatic test_reset();
        step_t s[$];
        step_t e;
        #3;
        n_total++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h want %h", rdata, 32'h0); else n_pass++;
        n_total++; if (exc_req !== 1'b0) $display("FAIL rst_exc_req got %0b want 0", exc_req); else n_pass++;
        n_total++; if (eret_req !== 1'b0) $display("FAIL rst_eret_req got %0b want 0", eret_req); else n_pass++;
        n_total++; if (epc_out !== 32'h0) $display("FAIL rst_epc got %h want %h", epc_out, 32'h0); else n_pass++;
        n_total++; if (exc_vector !== 32'h0000_4180) $display("FAIL exc_vector got %h want %h", exc_vector, 32'h0000_4180); else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        s.push_back(mk("rd_status", OP_MFC0, 12, 0, 0, 0, 0, 0, 0, 1, 32'h1, 0, 0));
        s.push_back(mk("rd_cause",  OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
        s.push_back(mk("rd_epc",    OP_MFC0, 14, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0));
        s.push_back(mk("rd_sel5",   OP_MFC0, 5,  0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            $display("txn %s exc=%0b eret=%0b rdata=%h epc=%h", e.name, exc_req, eret_req, rdata, epc_out);
            n_total++; if (exc_req !== e.exc) $display("FAIL %s exc_req got %0b want %0b", e.name, exc_req, e.exc); else n_pass++;
            n_total++; if (eret_req !== e.eret) $display("FAIL %s eret_req got %0b want %0b", e.name, eret_req, e.eret); else n_pass++;
            if (e.chk_rd) begin n_total++; if (rdata !== e.rd) $display("FAIL %s rdata got %h want %h", e.name, rdata, e.rd); else n_pass++; end
            if (e.chk_epc) begin n_total++; if (epc_out !== e.epc) $display("FAIL %s epc got %h want %h", e.name, epc_out, e.epc); else n_pass++; end
        end
    endtask

    task automatic test_syscall_eret();
        step_t s[$];
        step_t e;
        s.push_back(mk("sys",       OP_SYS,  0,  0, 32'h0040_0010, 0, 0, 1, 0, 0, 0, 1, 32'h0040_0010));
        s.push_back(mk("sys_cause", OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h20, 1, 32'h0040_0010));
        s.push_back(mk("sys_stat",  OP_MFC0, 12, 0, 0, 0, 0, 0, 0, 1, 32'h3, 0, 0));
        s.push_back(mk("eret",      OP_ERET, 0,  0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0040_0010));
        s.push_back(mk("eret_stat", OP_MFC0, 12, 0, 0, 0, 0, 0, 0, 1, 32'h1, 0, 0));
        s.push_back(mk("eret_code", OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            $display("txn %s exc=%0b eret=%0b rdata=%h epc=%h", e.name, exc_req, eret_req, rdata, epc_out);
            n_total++; if (exc_req !== e.exc) $display("FAIL %s exc_req got %0b want %0b", e.name, exc_req, e.exc); else n_pass++;
            n_total++; if (eret_req !== e.eret) $display("FAIL %s eret_req got %0b want %0b", e.name, eret_req, e.eret); else n_pass++;
            if (e.chk_rd) begin n_total++; if (rdata !== e.rd) $display("FAIL %s rdata got %h want %h", e.name, rdata, e.rd); else n_pass++; end
            if (e.chk_epc) begin n_total++; if (epc_out !== e.epc) $display("FAIL %s epc got %h want %h", e.name, epc_out, e.epc); else n_pass++; end
        end
    endtask

    task automatic test_exl_drop();
        step_t s[$];
        step_t e;
        s.push_back(mk("sys2",      OP_SYS,  0,  0, 32'h200, 0, 0, 1, 0, 0, 0, 1, 32'h200));
        s.push_back(mk("brk_drop",  OP_BRK,  0,  0, 32'h300, 0, 0, 0, 0, 0, 0, 1, 32'h200));
        s.push_back(mk("teq_drop",  OP_TEQ,  0,  0, 32'h304, 0, 1, 0, 0, 0, 0, 1, 32'h200));
        s.push_back(mk("code_kept", OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h20, 0, 0));
        s.push_back(mk("eret2",     OP_ERET, 0,  0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h200));
        s.push_back(mk("teq_false", OP_TEQ,  0,  0, 32'h400, 0, 0, 0, 0, 0, 0, 1, 32'h200));
        s.push_back(mk("teq_true",  OP_TEQ,  0,  0, 32'h404, 0, 1, 1, 0, 0, 0, 1, 32'h404));
        s.push_back(mk("teq_code",  OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h34, 0, 0));
        s.push_back(mk("eret3",     OP_ERET, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        s.push_back(mk("eret_idle", OP_ERET, 0,  0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h404));
        s.push_back(mk("idle_code", OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            $display("txn %s exc=%0b eret=%0b rdata=%h epc=%h", e.name, exc_req, eret_req, rdata, epc_out);
            n_total++; if (exc_req !== e.exc) $display("FAIL %s exc_req got %0b want %0b", e.name, exc_req, e.exc); else n_pass++;
            n_total++; if (eret_req !== e.eret) $display("FAIL %s eret_req got %0b want %0b", e.name, eret_req, e.eret); else n_pass++;
            if (e.chk_rd) begin n_total++; if (rdata !== e.rd) $display("FAIL %s rdata got %h want %h", e.name, rdata, e.rd); else n_pass++; end
            if (e.chk_epc) begin n_total++; if (epc_out !== e.epc) $display("FAIL %s epc got %h want %h", e.name, epc_out, e.epc); else n_pass++; end
        end
    endtask

    task automatic test_regs();
        step_t s[$];
        step_t e;
        s.push_back(mk("wr_stat_all", OP_MTC0, 12, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("rd_stat_all", OP_MFC0, 12, 0, 0, 0, 0, 0, 0, 1, 32'h0000_FF02, 0, 0));
        s.push_back(mk("wr_stat_rst", OP_MTC0, 12, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("wr_cause",    OP_MTC0, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("rd_cause_sw", OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 0));
        s.push_back(mk("wr_epc",      OP_MTC0, 14, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("rd_epc",      OP_MFC0, 14, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF));
        s.push_back(mk("wr_sel5_hold", OP_MTC0, 5, 32'h1234, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0));
        s.push_back(mk("rd_sel5",     OP_MFC0, 5,  0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
        s.push_back(mk("wr_im0",      OP_MTC0, 12, 32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("sw_int",      OP_NOP,  0,  0, 32'h700, 0, 0, 1, 0, 0, 0, 1, 32'h700));
        s.push_back(mk("clr_sw",      OP_MTC0, 13, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("sw_eret",     OP_ERET, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        s.push_back(mk("sw_quiet",    OP_NOP,  0,  0, 32'h704, 0, 0, 0, 0, 0, 0, 1, 32'h700));
        s.push_back(mk("stat_back",   OP_MTC0, 12, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            $display("txn %s exc=%0b eret=%0b rdata=%h epc=%h", e.name, exc_req, eret_req, rdata, epc_out);
            n_total++; if (exc_req !== e.exc) $display("FAIL %s exc_req got %0b want %0b", e.name, exc_req, e.exc); else n_pass++;
            n_total++; if (eret_req !== e.eret) $display("FAIL %s eret_req got %0b want %0b", e.name, eret_req, e.eret); else n_pass++;
            if (e.chk_rd) begin n_total++; if (rdata !== e.rd) $display("FAIL %s rdata got %h want %h", e.name, rdata, e.rd); else n_pass++; end
            if (e.chk_epc) begin n_total++; if (epc_out !== e.epc) $display("FAIL %s epc got %h want %h", e.name, epc_out, e.epc); else n_pass++; end
        end
    endtask

    task automatic test_priority();
        step_t s[$];
        step_t e;
        s.push_back(mk("im2_set",    OP_MTC0, 12, 32'h401, 0, 6'h1, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("brk_vs_irq", OP_BRK,  0,  0, 32'h100, 6'h1, 0, 1, 0, 0, 0, 1, 32'h100));
        s.push_back(mk("brk_code",   OP_MFC0, 13, 0, 0, 6'h1, 0, 0, 0, 1, 32'h424, 0, 0));
        s.push_back(mk("eret_noint", OP_ERET, 0,  0, 32'h500, 6'h1, 0, 0, 1, 0, 0, 0, 0));
        s.push_back(mk("late_int",   OP_NOP,  0,  0, 32'h504, 6'h1, 0, 1, 0, 0, 0, 1, 32'h504));
        s.push_back(mk("int_code",   OP_MFC0, 13, 0, 0, 6'h0, 0, 0, 0, 1, 32'h400, 0, 0));
        s.push_back(mk("int_eret",   OP_ERET, 0,  0, 0, 6'h0, 0, 0, 1, 0, 0, 0, 0));
        s.push_back(mk("ie_off",     OP_MTC0, 12, 32'h400, 0, 6'h1, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("ie_masked",  OP_NOP,  0,  0, 32'h5F0, 6'h1, 0, 0, 0, 0, 0, 1, 32'h504));
        s.push_back(mk("ie_on_mtc0", OP_MTC0, 12, 32'h401, 32'h5F4, 6'h1, 0, 0, 0, 0, 0, 1, 32'h504));
        s.push_back(mk("ie_took",    OP_NOP,  0,  0, 32'h600, 6'h1, 0, 1, 0, 0, 0, 1, 32'h600));
        s.push_back(mk("brk_in_exl", OP_BRK,  0,  0, 32'h604, 6'h1, 0, 0, 0, 0, 0, 1, 32'h600));
        s.push_back(mk("eret4",      OP_ERET, 0,  0, 0, 6'h0, 0, 0, 1, 0, 0, 0, 0));
        s.push_back(mk("irq_gone",   OP_NOP,  0,  0, 32'h608, 6'h0, 0, 0, 0, 0, 0, 1, 32'h600));
        s.push_back(mk("im_clear",   OP_MTC0, 12, 32'h1, 0, 6'h0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            $display("txn %s exc=%0b eret=%0b rdata=%h epc=%h", e.name, exc_req, eret_req, rdata, epc_out);
            n_total++; if (exc_req !== e.exc) $display("FAIL %s exc_req got %0b want %0b", e.name, exc_req, e.exc); else n_pass++;
            n_total++; if (eret_req !== e.eret) $display("FAIL %s eret_req got %0b want %0b", e.name, eret_req, e.eret); else n_pass++;
            if (e.chk_rd) begin n_total++; if (rdata !== e.rd) $display("FAIL %s rdata got %h want %h", e.name, rdata, e.rd); else n_pass++; end
            if (e.chk_epc) begin n_total++; if (epc_out !== e.epc) $display("FAIL %s epc got %h want %h", e.name, epc_out, e.epc); else n_pass++; end
        end
    endtask

    task automatic test_timer();
        step_t s[$];
        step_t e;
        s.push_back(mk("wr_count",   OP_MTC0, 9,  32'd10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("wr_compare", OP_MTC0, 11, 32'd15, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("tick2",      OP_NOP,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("tick3",      OP_NOP,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("ti_low4",    OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
        s.push_back(mk("ti_low5",    OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
        s.push_back(mk("ti_high",    OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h4000_8000, 0, 0));
        s.push_back(mk("im7_set",    OP_MTC0, 12, 32'h8001, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("timer_int",  OP_NOP,  0,  0, 32'h800, 0, 0, 1, 0, 0, 0, 1, 32'h800));
        s.push_back(mk("timer_code", OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h4000_8000, 0, 0));
        s.push_back(mk("ti_clear",   OP_MTC0, 11, 32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("timer_eret", OP_ERET, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        s.push_back(mk("ti_quiet",   OP_NOP,  0,  0, 32'h804, 0, 0, 0, 0, 0, 0, 1, 32'h800));
        s.push_back(mk("ti_gone",    OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
        s.push_back(mk("im7_clr",    OP_MTC0, 12, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("cnt_max",    OP_MTC0, 9,  32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk("rd_cnt_max", OP_MFC0, 9,  0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0));
        s.push_back(mk("rd_cnt_0",   OP_MFC0, 9,  0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
        s.push_back(mk("rd_cnt_1",   OP_MFC0, 9,  0, 0, 0, 0, 0, 0, 1, 32'h1, 0, 0));
        s.push_back(mk("rd_compare", OP_MFC0, 11, 0, 0, 0, 0, 0, 0, 1, 32'h7FFF_FFFF, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            $display("txn %s exc=%0b eret=%0b rdata=%h epc=%h", e.name, exc_req, eret_req, rdata, epc_out);
            n_total++; if (exc_req !== e.exc) $display("FAIL %s exc_req got %0b want %0b", e.name, exc_req, e.exc); else n_pass++;
            n_total++; if (eret_req !== e.eret) $display("FAIL %s eret_req got %0b want %0b", e.name, eret_req, e.eret); else n_pass++;
            if (e.chk_rd) begin n_total++; if (rdata !== e.rd) $display("FAIL %s rdata got %h want %h", e.name, rdata, e.rd); else n_pass++; end
            if (e.chk_epc) begin n_total++; if (epc_out !== e.epc) $display("FAIL %s epc got %h want %h", e.name, epc_out, e.epc); else n_pass++; end
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        step_t e;
        s.push_back(mk("sys_pre_rst", OP_SYS,  0,  0, 32'h900, 0, 0, 1, 0, 0, 0, 1, 32'h900));
        s.push_back(mk("post_stat",   OP_MFC0, 12, 0, 0, 0, 0, 0, 0, 1, 32'h1, 1, 32'h0));
        s.push_back(mk("post_cause",  OP_MFC0, 13, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 32'h0));
        foreach (s[i]) begin
            apply(s[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            $display("txn %s exc=%0b eret=%0b rdata=%h epc=%h", e.name, exc_req, eret_req, rdata, epc_out);
            n_total++; if (exc_req !== e.exc) $display("FAIL %s exc_req got %0b want %0b", e.name, exc_req, e.exc); else n_pass++;
            n_total++; if (eret_req !== e.eret) $display("FAIL %s eret_req got %0b want %0b", e.name, eret_req, e.eret); else n_pass++;
            if (e.chk_rd) begin n_total++; if (rdata !== e.rd) $display("FAIL %s rdata got %h want %h", e.name, rdata, e.rd); else n_pass++; end
            if (e.chk_epc) begin n_total++; if (epc_out !== e.epc) $display("FAIL %s epc got %h want %h", e.name, epc_out, e.epc); else n_pass++; end
            if (i == 0) begin
                // Pulse is high right now: pull reset mid-cycle.
                op  = OP_NOP;
                rst = 1'b1;
                #1;
                $display("txn mid_reset exc=%0b epc=%h", exc_req, epc_out);
                n_total++; if (exc_req !== 1'b0) $display("FAIL mid_rst_exc got %0b want 0", exc_req); else n_pass++;
                n_total++; if (epc_out !== 32'h0) $display("FAIL mid_rst_epc got %h want %h", epc_out, 32'h0); else n_pass++;
                @(posedge clk); #1;
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        op       = OP_NOP;
        sel      = '0;
        wdata    = '0;
        teq_cond = 1'b0;
        pc_in    = '0;
        irq      = '0;
        test_reset();
        test_syscall_eret();
        test_exl_drop();
        test_regs();
        test_priority();
        test_timer();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
